fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/DFFRE.sv | 22 ++
 rtl/rr_arb_lib.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write arbiter and its round-robin picker.
// The credit width function sizes a counter that must hold 0..ENT_NUM inclusive.
package fifo_arb_pkg;

    localparam int DEF_REQ_NUM   = 4;
    localparam int DEF_ENT_NUM   = 4;
    localparam int DEF_DATA_SIZE = 32;
    localparam int STALL_CNT_W   = 16;

    function automatic int credit_w(input int ent_num);
        return $clog2(ent_num + 1);
    endfunction

endpackage

// File: rtl/DFFRE.sv
// Library enable flop with asynchronous active-low reset to a parameterised value.
// Latency: one cycle; q holds whenever en is low.
module DFFRE #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_arb_lib.sv
// Purely combinational one-hot round-robin picker: highest priority is last_ptr+1, wrapping.
// Zero latency; no state, so it can be shared by any arbiter that owns its own pointer.
module rr_arb_lib #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last_ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(last_ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter pushing into a credited FIFO; grant is same-cycle combinational.
// Never pushes with zero credits; a pop at full credit with no push sets sticky credit_err.
// Optional FIFO_WR_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int REQ_NUM   = DEF_REQ_NUM,
    parameter int ENT_NUM   = DEF_ENT_NUM,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_NUM-1:0]             req_vld,
    input  logic [REQ_NUM*DATA_SIZE-1:0]   req_data,
    output logic [REQ_NUM-1:0]             req_gnt,
    output logic                           fifo_in_vld,
    output logic [DATA_SIZE-1:0]           fifo_in_data,
    input  logic                           fifo_pop,
    output logic [credit_w(ENT_NUM)-1:0]   credit_cnt,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]         stall_cnt,
`endif
    output logic                           credit_err
);

    localparam int             CW       = credit_w(ENT_NUM);
    localparam int             PW       = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam logic [CW-1:0]  CRED_MAX = CW'(ENT_NUM);
    localparam logic [PW-1:0]  PTR_RST  = PW'(REQ_NUM - 1);

    logic [PW-1:0]      last_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [REQ_NUM-1:0] pick;
    logic               push;
    logic               underflow;
    logic               cred_en;
    logic [CW-1:0]      cred_nxt;

    rr_arb_lib #(
        .N  (REQ_NUM),
        .PW (PW)
    ) u_rr_arb (
        .req      (req_vld),
        .last_ptr (last_ptr),
        .gnt      (pick)
    );

    // A pop seen at zero credit only takes effect next cycle, so gating on the registered count suffices.
    assign req_gnt     = (rst_n && (credit_cnt != '0)) ? pick : '0;
    assign fifo_in_vld = |req_gnt;
    assign push        = fifo_in_vld;

    always_comb begin
        gnt_idx      = '0;
        fifo_in_data = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req_gnt[i]) begin
                gnt_idx = gnt_idx | PW'(i);
            end
            fifo_in_data = fifo_in_data | (req_data[i*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{req_gnt[i]}});
        end
    end

    assign underflow = fifo_pop && !push && (credit_cnt == CRED_MAX);
    assign cred_en   = (push != fifo_pop) && !underflow;
    assign cred_nxt  = push ? (credit_cnt - CW'(1)) : (credit_cnt + CW'(1));

    DFFRE #(.W(CW), .RST_VAL(CRED_MAX)) u_credit_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cred_en),
        .d     (cred_nxt),
        .q     (credit_cnt)
    );

    DFFRE #(.W(PW), .RST_VAL(PTR_RST)) u_ptr_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push),
        .d     (gnt_idx),
        .q     (last_ptr)
    );

    DFFRE #(.W(1), .RST_VAL(1'b0)) u_err_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (underflow),
        .d     (1'b1),
        .q     (credit_err)
    );

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic stall_en;

    assign stall_en = (|req_vld) && (credit_cnt == '0) && (stall_cnt != {STALL_CNT_W{1'b1}});

    DFFRE #(.W(STALL_CNT_W), .RST_VAL('0)) u_stall_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .d     (stall_cnt + STALL_CNT_W'(1)),
        .q     (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios with hand-derived expectations, then a randomized phase against a reference model.
module tb_fifo_wr_arbiter;

    localparam int RN = 4;
    localparam int EN = 4;
    localparam int DS = 32;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RN-1:0]     req_vld;
    logic [RN*DS-1:0]  req_data;
    logic [RN-1:0]     req_gnt;
    logic              fifo_in_vld;
    logic [DS-1:0]     fifo_in_data;
    logic              fifo_pop;
    logic [CW-1:0]     credit_cnt;
    logic              credit_err;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    typedef struct {
        string         tag;
        logic [RN-1:0] gnt;
        logic [CW-1:0] cred;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fifo_wr_arbiter #(.REQ_NUM(RN), .ENT_NUM(EN), .DATA_SIZE(DS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_data     (req_data),
        .req_gnt      (req_gnt),
        .fifo_in_vld  (fifo_in_vld),
        .fifo_in_data (fifo_in_data),
        .fifo_pop     (fifo_pop),
        .credit_cnt   (credit_cnt),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, queue the expectation, compare once outputs settle.
    task automatic cycle(input string tag, input logic [RN-1:0] vld, input logic pop,
                         input logic [RN-1:0] eg, input int ec, input logic ee);
        exp_t          e;
        logic [DS-1:0] ed;
        @(negedge clk);
        for (int i = 0; i < RN; i++) begin
            if (!req_vld[i]) req_data[i*DS +: DS] = $urandom;
        end
        req_vld  = vld;
        fifo_pop = pop;
        e.tag  = tag;
        e.gnt  = eg;
        e.cred = CW'(ec);
        e.err  = ee;
        sb.push_back(e);
        #2;
        e  = sb.pop_front();
        ed = '0;
        for (int i = 0; i < RN; i++) begin
            if (e.gnt[i]) ed = req_data[i*DS +: DS];
        end
        check({e.tag, ".gnt"},  32'(req_gnt),     32'(e.gnt));
        check({e.tag, ".vld"},  32'(fifo_in_vld), 32'(|e.gnt));
        check({e.tag, ".data"}, fifo_in_data,     ed);
        check({e.tag, ".cred"}, 32'(credit_cnt),  32'(e.cred));
        check({e.tag, ".err"},  32'(credit_err),  32'(e.err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req_vld  = '1;
        fifo_pop = 1'b0;
        #2;
        check("rst.gnt",  32'(req_gnt),     32'd0);
        check("rst.vld",  32'(fifo_in_vld), 32'd0);
        check("rst.cred", 32'(credit_cnt),  32'(EN));
        check("rst.err",  32'(credit_err),  32'd0);
        @(negedge clk);
        req_vld = '0;
        rst_n   = 1'b1;
    endtask

    initial begin
        int            m_last;
        int            m_cred;
        logic [RN-1:0] hold;
        logic [RN-1:0] eg;
        logic          pop;
        int            idx;

        rst_n    = 1'b0;
        req_vld  = '0;
        req_data = '0;
        fifo_pop = 1'b0;
        do_reset();

        // All requesters active, no pops: rotate 0..3 and run out of credit.
        cycle("r26a", 4'b1111, 1'b0, 4'b0001, 4, 1'b0);
        cycle("r26b", 4'b1111, 1'b0, 4'b0010, 3, 1'b0);
        cycle("r26c", 4'b1111, 1'b0, 4'b0100, 2, 1'b0);
        cycle("r26d", 4'b1111, 1'b0, 4'b1000, 1, 1'b0);
        cycle("r26e", 4'b1111, 1'b0, 4'b0000, 0, 1'b0);

        // Pop at zero credit does not enable a same-cycle push.
        cycle("r27a", 4'b0100, 1'b1, 4'b0000, 0, 1'b0);
        cycle("r27b", 4'b0100, 1'b0, 4'b0100, 1, 1'b0);

        // Push and pop together at credit 2.
        cycle("r28s0", 4'b0000, 1'b1, 4'b0000, 0, 1'b0);
        cycle("r28s1", 4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        cycle("r28a",  4'b0001, 1'b1, 4'b0001, 2, 1'b0);
        cycle("r28b",  4'b0000, 1'b0, 4'b0000, 2, 1'b0);

        // Last grant 2 with requesters 0 and 2: 0 first, then 2.
        cycle("r30s", 4'b0100, 1'b1, 4'b0100, 2, 1'b0);
        cycle("r30a", 4'b0101, 1'b1, 4'b0001, 2, 1'b0);
        cycle("r30b", 4'b0100, 1'b0, 4'b0100, 2, 1'b0);
        cycle("r12",  4'b0000, 1'b0, 4'b0000, 1, 1'b0);

        // Underflow at full credit: error is sticky, count holds.
        cycle("r29s0", 4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        cycle("r29s1", 4'b0000, 1'b1, 4'b0000, 2, 1'b0);
        cycle("r29s2", 4'b0000, 1'b1, 4'b0000, 3, 1'b0);
        cycle("r29a",  4'b0000, 1'b1, 4'b0000, 4, 1'b0);
        cycle("r29b",  4'b0000, 1'b0, 4'b0000, 4, 1'b1);
        cycle("r29c",  4'b0001, 1'b0, 4'b0001, 4, 1'b1);
        cycle("r29d",  4'b0000, 1'b0, 4'b0000, 3, 1'b1);
        do_reset();

`ifdef FIFO_WR_ARB_STALL_CNT_EN
        cycle("st0", 4'b1111, 1'b0, 4'b0001, 4, 1'b0);
        cycle("st1", 4'b1110, 1'b0, 4'b0010, 3, 1'b0);
        cycle("st2", 4'b1100, 1'b0, 4'b0100, 2, 1'b0);
        cycle("st3", 4'b1000, 1'b0, 4'b1000, 1, 1'b0);
        for (int n = 0; n < 10; n++) cycle("stall", 4'b0001, 1'b0, 4'b0000, 0, 1'b0);
        @(negedge clk);
        req_vld = '0;
        #2;
        check("stall_cnt", 32'(stall_cnt), 32'd10);
        do_reset();
`endif

        // Randomized traffic with requesters that hold until granted or occasionally drop.
        m_last = RN - 1;
        m_cred = EN;
        hold   = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < RN; i++) begin
                if (!hold[i] && $urandom_range(0, 2) == 0) hold[i] = 1'b1;
                else if (hold[i] && $urandom_range(0, 19) == 0) hold[i] = 1'b0;
            end
            pop = (m_cred < EN) && ($urandom_range(0, 1) == 1);
            eg  = '0;
            if (m_cred > 0) begin
                for (int k = 1; k <= RN; k++) begin
                    idx = (m_last + k) % RN;
                    if (hold[idx] && eg == '0) eg[idx] = 1'b1;
                end
            end
            cycle("rand", hold, pop, eg, m_cred, 1'b0);
            for (int i = 0; i < RN; i++) begin
                if (eg[i]) begin
                    m_last  = i;
                    hold[i] = 1'b0;
                end
            end
            m_cred = m_cred - ((eg != '0) ? 1 : 0) + (pop ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
